// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store requester and data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word loads and stores.
// Clears itself after reset, then accepts one request per cycle and
// returns one registered response on the following cycle.
module data_mem_ctrl #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus,
  output logic           init_done
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              fire;
  logic              oob;
  logic              err_c;

  assign addr = bus.req_addr;
  assign idx  = addr[IDX_W+1:2];
  assign lane = addr[1:0];
  assign fire = bus.req_valid & ready_q;
  // Any address bit above the word index puts the access past the array.
  assign oob  = |(addr >> (IDX_W + 2));

  // Illegal size, misaligned half/word, or out-of-range address.
  always_comb begin
    err_c = oob;
    case (bus.req_size)
      SZ_BYTE: err_c = oob;
      SZ_HALF: err_c = oob | lane[0];
      SZ_WORD: err_c = oob | (lane != 2'b00);
      default: err_c = 1'b1;
    endcase
  end

  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Byte enables and lane-replicated store data.
  always_comb begin
    st_be   = 4'b0000;
    st_data = bus.req_wdata;
    case (bus.req_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{bus.req_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = 4'b0011 << lane;
        st_data = {2{bus.req_wdata[15:0]}};
      end
      SZ_WORD: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wd;

  // Single write port shared between the clear sweep and legal stores.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = idx;
    mem_be  = st_be;
    mem_wd  = st_data;
    if (state == ST_INIT) begin
      mem_we  = 1'b1;
      mem_idx = clr_cnt;
      mem_be  = 4'b1111;
      mem_wd  = '0;
    end else if (fire && bus.req_we && !err_c) begin
      mem_we  = 1'b1;
    end
  end

  // Byte-lane memory write; contents are defined only after the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][b*8 +: 8] <= mem_wd[b*8 +: 8];
        end
      end
    end
  end

  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;

  // Read at the accepting edge so a store one cycle earlier is already visible.
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  // Sub-word extraction with sign or zero extension.
  always_comb begin
    ld_data = rd_word;
    case (bus.req_size)
      SZ_BYTE: ld_data = {{24{~bus.req_unsigned & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: ld_data = {{16{~bus.req_unsigned & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  // Controller state, clear counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      clr_cnt     <= '0;
      ready_q     <= 1'b0;
      init_done   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= fire;
      rsp_err_q   <= fire & err_c;
      rsp_rdata_q <= (fire && !bus.req_we && !err_c) ? ld_data : '0;
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            ready_q   <= 1'b1;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q   <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: clear timing, directed vector table, random
// traffic against a byte-addressed reference memory, and mid-operation reset.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned AW     = 16;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst;
  logic init_done;

  data_mem_ctrl_if #(.ADDR_W(AW)) bus ();

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ntag   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          tag;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
    logic          exp_err;
    logic [31:0]   exp_rdata;
  } vec_t;

  exp_t       expq[$];
  exp_t       me;
  vec_t       vecs[$];
  logic [7:0] ref_mem [NBYTES];

  task automatic check(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s #%0d: got 0x%08h, required 0x%08h", name, tag, act, req);
    end
  endtask

  // Byte-addressed little-endian reference memory.
  function automatic void model(input logic we, input logic [AW-1:0] addr,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
    int n;
    int a;
    logic [31:0] v;
    a = int'(addr);
    n = 1 << size;
    err = (size == 2'd3) || ((a % n) != 0) || (a >= int'(NBYTES));
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a+i];
      if (!uns && n < 4 && v[8*n-1]) begin
        for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      end
      rdata = v;
    end
  endfunction

  // Drive one request for the next edge and queue its expected response.
  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] wdata, input bit use_tbl,
                       input logic tbl_err, input logic [31:0] tbl_rdata);
    exp_t e;
    logic m_err;
    logic [31:0] m_rdata;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    check("req_ready", ntag, 32'(bus.req_ready), 32'd1);
    if (bus.req_ready) begin
      model(we, addr, size, uns, wdata, m_err, m_rdata);
      e.err   = use_tbl ? tbl_err : m_err;
      e.rdata = use_tbl ? tbl_rdata : m_rdata;
      e.cyc   = cyc + 1;
      e.tag   = ntag;
      expq.push_back(e);
    end
    ntag++;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_addr     = AW'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_wdata    = $urandom;
  endtask

  // Hold reset, check reset outputs, release and time the clear sweep.
  task automatic reset_and_clear(input int tag);
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    expq.delete();
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    check("rst_rsp_valid", tag, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("rst_req_ready", tag, 32'(bus.req_ready), 32'd0);
    check("rst_init_done", tag, 32'(init_done), 32'd0);
    check("rst_rsp_rdata", tag, bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", tag, 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    n = 0;
    while (!bus.req_ready && n < int'(4 * DEPTH)) begin
      @(negedge clk);
      n++;
    end
    check("clear_cycles", tag, 32'(n), 32'(DEPTH));
    check("init_done", tag, 32'(init_done), 32'd1);
  endtask

  // Response monitor: ordering, one-cycle latency, idle outputs zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          me = expq.pop_front();
          check("rsp_cycle", me.tag, 32'(cyc), 32'(me.cyc));
          check("rsp_err", me.tag, 32'(bus.rsp_err), 32'(me.err));
          check("rsp_rdata", me.tag, bus.rsp_rdata, me.rdata);
        end
      end else begin
        if (expq.size() != 0 && expq[0].cyc <= cyc) begin
          me = expq.pop_front();
          checks++;
          errors++;
          $display("FAIL rsp_missing #%0d: rsp_valid=0 at cycle %0d, required 1", me.tag, cyc);
        end
        check("idle_rdata", cyc, bus.rsp_rdata, 32'd0);
        check("idle_err", cyc, 32'(bus.rsp_err), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [1:0]    sz;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;

    reset_and_clear(0);

    // Every word reads back zero after the clear sweep.
    for (int w = 0; w < int'(DEPTH); w++) issue(1'b0, AW'(w * 4), 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Directed vectors: {we, addr, size, unsigned, wdata, err, rdata}
    vecs.push_back('{1'b1, 16'h0040, 2'b10, 1'b0, 32'h80FF7F01, 1'b0, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0040, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'h00000001});
    vecs.push_back('{1'b0, 16'h0041, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'h0000007F});
    vecs.push_back('{1'b0, 16'h0042, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 16'h0043, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'hFFFFFF80});
    vecs.push_back('{1'b0, 16'h0043, 2'b00, 1'b1, 32'h00000000, 1'b0, 32'h00000080});
    vecs.push_back('{1'b0, 16'h0042, 2'b01, 1'b0, 32'h00000000, 1'b0, 32'hFFFF80FF});
    vecs.push_back('{1'b0, 16'h0042, 2'b01, 1'b1, 32'h00000000, 1'b0, 32'h000080FF});
    vecs.push_back('{1'b0, 16'h0040, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'h80FF7F01});
    vecs.push_back('{1'b1, 16'h0008, 2'b10, 1'b0, 32'h11223344, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 16'h000A, 2'b01, 1'b0, 32'h0000BEEF, 1'b0, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0008, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'hBEEF3344});
    vecs.push_back('{1'b0, 16'h0008, 2'b01, 1'b1, 32'h00000000, 1'b0, 32'h00003344});
    vecs.push_back('{1'b1, 16'h0009, 2'b00, 1'b0, 32'hFFFFFFAA, 1'b0, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0008, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'hBEEFAA44});
    vecs.push_back('{1'b1, 16'h0001, 2'b01, 1'b0, 32'h0000FFFF, 1'b1, 32'h00000000});
    vecs.push_back('{1'b1, 16'h0002, 2'b10, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h00000000});
    vecs.push_back('{1'b1, 16'h0040, 2'b11, 1'b0, 32'h00000000, 1'b1, 32'h00000000});
    vecs.push_back('{1'b1, 16'h0100, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0041, 2'b01, 1'b0, 32'h00000000, 1'b1, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0042, 2'b10, 1'b0, 32'h00000000, 1'b1, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0100, 2'b00, 1'b0, 32'h00000000, 1'b1, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0000, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0040, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'h80FF7F01});
    vecs.push_back('{1'b1, 16'h0010, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h00000000});
    vecs.push_back('{1'b0, 16'h0010, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'hA5A5A5A5});
    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
            1'b1, vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // Random traffic against the reference memory, with occasional gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) a = AW'($urandom);
      else a = AW'($urandom_range(0, NBYTES - 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~AW'((1 << sz) - 1);
      issue(1'($urandom), a, sz, 1'($urandom), $urandom, 1'b0, 1'b0, 32'h0);
      if ($urandom_range(0, 5) == 0) idle();
    end
    idle();
    idle();

    // Reset while a load response is in flight: it must be dropped.
    issue(1'b1, 16'h0020, 2'b10, 1'b0, 32'h12345678, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 16'h0020, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    reset_and_clear(1);
    issue(1'b0, 16'h0020, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000000);
    issue(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000000);
    issue(1'b0, 16'h0040, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000000);
    for (int i = 0; i < 4; i++) idle();
    check("drain", 0, 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
